mem_bus_ctrl: RTL and testbench

Sequencer and arbiter for the processor's 16-bit external memory bus, shared between the instruction-fetch unit and the load/store unit. It generates the address, `rd`/`wr` strobes and data-drive enable for the 32K x 16 EPROM (address bit 15 = 1) and the RAM (address bit 15 = 0), inserting per-region wait states. For fetches it assembles each two-word instruction into one 32-bit result. It sits between the CPU core and the top-level tristate/bus wiring, and holds off new cycles during interrupt acknowledge.

---
 rtl/mem_bus_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - external 16-bit memory bus sequencer with ls/if arbitration
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr/if_ack/if_instr
//                               fetch port, two words assembled into 32 bits
//   ls_req/ls_we/ls_addr/ls_wdata/ls_ack/ls_err/ls_rdata
//                               load/store port, single 16-bit access
//   inta                        blocks new grants while high
//   address_bus/data_in/data_out/data_oe/rd/wr
//                               external bus toward the tristate wiring
module mem_bus_ctrl #(
  parameter int WAIT_EPROM = 2,
  parameter int WAIT_RAM   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_instr,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  output logic        ls_ack,
  output logic        ls_err,
  output logic [15:0] ls_rdata,
  input  logic        inta,
  output logic [15:0] address_bus,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        rd,
  output logic        wr
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t     state, state_nxt;
  logic       cur_if;      // granted requester is the fetch unit
  logic       cur_we;      // granted access is a write
  logic       word1;       // fetch is on its second word
  logic       fav_if;      // last completed transaction was ls
  logic [7:0] wait_cnt;    // remaining extra strobe cycles

  logic       grant_ls, grant_if;
  logic       last_strobe;
  logic       nxt_wr_ok;   // write that may actually drive the bus (RAM only)
  logic [7:0] wait_load;

  always_comb begin
    state_nxt   = state;
    grant_ls    = ls_req && !(fav_if && if_req);
    grant_if    = if_req && !grant_ls;
    last_strobe = (wait_cnt == 8'd0);
    nxt_wr_ok   = cur_we && !address_bus[15];
    wait_load   = address_bus[15] ? 8'(WAIT_EPROM) : 8'(WAIT_RAM);
    case (state)
      IDLE: begin
        if (!inta && (ls_req || if_req)) begin
          state_nxt = SETUP;
          // Latched fields are not loaded yet, so look at the winner directly.
          nxt_wr_ok = grant_ls && ls_we && !ls_addr[15];
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: begin
        if (last_strobe) begin
          state_nxt = (cur_if && !word1) ? SETUP : DONE;
        end
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_if      <= 1'b0;
      cur_we      <= 1'b0;
      word1       <= 1'b0;
      fav_if      <= 1'b0;
      wait_cnt    <= 8'd0;
      if_ack      <= 1'b0;
      if_instr    <= 32'd0;
      ls_ack      <= 1'b0;
      ls_err      <= 1'b0;
      ls_rdata    <= 16'd0;
      address_bus <= 16'd0;
      data_out    <= 16'd0;
      data_oe     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
    end else begin
      state   <= state_nxt;
      if_ack  <= 1'b0;
      ls_ack  <= 1'b0;
      ls_err  <= 1'b0;
      // Strobes are registered from the next state so they line up with it.
      rd      <= (state_nxt == STROBE) && !cur_we;
      wr      <= (state_nxt == STROBE) && nxt_wr_ok;
      data_oe <= ((state_nxt == SETUP) || (state_nxt == STROBE)) && nxt_wr_ok;
      case (state)
        IDLE: begin
          if (state_nxt == SETUP) begin
            cur_if      <= grant_if;
            cur_we      <= grant_ls && ls_we;
            word1       <= 1'b0;
            address_bus <= grant_if ? if_addr : ls_addr;
            if (grant_ls) data_out <= ls_wdata;
          end
        end
        SETUP: wait_cnt <= wait_load;
        STROBE: begin
          if (!last_strobe) begin
            wait_cnt <= wait_cnt - 8'd1;
          end else begin
            if (!cur_if) begin
              if (!cur_we) ls_rdata <= data_in;
            end else if (!word1) begin
              if_instr[31:16] <= data_in;
              word1           <= 1'b1;
              // Second word stays in the same region; the offset wraps.
              address_bus     <= {address_bus[15], address_bus[14:0] + 15'd1};
            end else begin
              if_instr[15:0] <= data_in;
            end
            if (state_nxt == DONE) begin
              if_ack <= cur_if;
              ls_ack <= !cur_if;
              ls_err <= !cur_if && cur_we && address_bus[15];
              fav_if <= !cur_if;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
  localparam int WAIT_EPROM = 2;
  localparam int WAIT_RAM   = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack;
  logic        ls_err;
  logic [15:0] ls_rdata;
  logic        inta;
  logic [15:0] address_bus;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        rd;
  logic        wr;

  int checks = 0;
  int failures = 0;

  logic [15:0] bus_mem [0:65535];
  logic [15:0] ref_mem [0:65535];

  mem_bus_ctrl #(.WAIT_EPROM(WAIT_EPROM), .WAIT_RAM(WAIT_RAM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .inta(inta),
    .address_bus(address_bus), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .rd(rd), .wr(wr)
  );

  always #5 clk = ~clk;

  assign data_in = bus_mem[address_bus];
  always @(posedge clk) if (wr) bus_mem[address_bus] <= data_out;

  task automatic set_word(input logic [15:0] a, input logic [15:0] d);
    bus_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; inta = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({if_ack, if_instr, ls_ack, ls_err, ls_rdata, address_bus, data_out, data_oe, rd, wr} !== '0) begin
      failures++;
      $display("FAIL %s: outputs not zero: addr=%h dout=%h instr=%h rdata=%h ctl=%b", name,
               address_bus, data_out, if_instr, ls_rdata, {if_ack, ls_ack, ls_err, data_oe, rd, wr});
    end
  endtask

  // One complete transaction from an idle bus; expected timeline derived from
  // the region wait count and the number of words.
  task automatic run_txn(input bit is_if, input bit we_in, input logic [15:0] addr,
                         input logic [15:0] wdata, input int inta_hold, input bit mid_inta);
    int          w, lat, nwords, j, pos;
    bit          we, eprom_wr, wr_ok, active, setup, strobe;
    logic [15:0] a [2];
    logic [15:0] exp_d0, exp_d1;
    logic [5:0]  exp_ctl, got_ctl;
    we       = we_in && !is_if;
    w        = addr[15] ? WAIT_EPROM : WAIT_RAM;
    nwords   = is_if ? 2 : 1;
    lat      = 1 + nwords * (2 + w);
    a[0]     = addr;
    a[1]     = {addr[15], addr[14:0] + 15'd1};
    eprom_wr = we && addr[15];
    wr_ok    = we && !addr[15];
    exp_d0   = ref_mem[a[0]];
    exp_d1   = ref_mem[a[1]];
    @(negedge clk);
    if_addr = addr; ls_addr = addr; ls_we = we; ls_wdata = wdata;
    if_req = is_if; ls_req = !is_if;
    if (inta_hold > 0) begin
      inta = 1'b1;
      repeat (inta_hold) begin
        @(negedge clk);
        checks++;
        if ({rd, wr, if_ack, ls_ack} !== 4'b0) begin
          failures++;
          $display("FAIL inta_hold: activity %b while inta high, required 0000", {rd, wr, if_ack, ls_ack});
        end
      end
      inta = 1'b0;
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (mid_inta && k == 2) inta = 1'b1;
      j      = (k - 1) / (2 + w);
      pos    = (k - 1) % (2 + w);
      active = (k < lat);
      setup  = active && (pos == 0);
      strobe = active && (pos >= 1);
      exp_ctl = {strobe && !we, strobe && wr_ok, (setup || strobe) && wr_ok,
                 is_if && k == lat, !is_if && k == lat, eprom_wr && k == lat};
      got_ctl = {rd, wr, data_oe, if_ack, ls_ack, ls_err};
      checks++;
      if (got_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl addr=%h if=%0d we=%0d cycle %0d: rd/wr/oe/ifack/lsack/err=%b required %b",
                 addr, is_if, we, k, got_ctl, exp_ctl);
      end
      if (active) begin
        checks++;
        if (address_bus !== a[j]) begin
          failures++;
          $display("FAIL address cycle %0d: got %h required %h", k, address_bus, a[j]);
        end
      end
      if (strobe && wr_ok) begin
        checks++;
        if (data_out !== wdata) begin
          failures++;
          $display("FAIL data_out cycle %0d: got %h required %h", k, data_out, wdata);
        end
      end
    end
    if (is_if) begin
      checks++;
      if (if_instr !== {exp_d0, exp_d1}) begin
        failures++;
        $display("FAIL if_instr addr=%h: got %h required %h", addr, if_instr, {exp_d0, exp_d1});
      end
    end else if (!we) begin
      checks++;
      if (ls_rdata !== exp_d0) begin
        failures++;
        $display("FAIL ls_rdata addr=%h: got %h required %h", addr, ls_rdata, exp_d0);
      end
    end
    if (wr_ok) ref_mem[addr] = wdata;
    if_req = 1'b0; ls_req = 1'b0; inta = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; inta = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_eprom_read();
    set_word(16'h8004, 16'h8042);
    run_txn(1'b0, 1'b0, 16'h8004, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_fetch();
    set_word(16'h8000, 16'h8000);
    set_word(16'h8001, 16'h4801);
    run_txn(1'b1, 1'b0, 16'h8000, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h7FFF, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_ram_write();
    run_txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_eprom_write();
    run_txn(1'b0, 1'b1, 16'h8010, 16'h1234, 0, 1'b0);
    run_txn(1'b0, 1'b0, 16'h8010, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit  last_ls, exp_if;
    int  nacks, strobes, exp_str;
    logic prev_rd;
    do_reset();
    last_ls = 1'b0;
    @(negedge clk);
    ls_addr = 16'h0020; ls_we = 1'b0; if_addr = 16'h0040;
    ls_req = 1'b1; if_req = 1'b1;
    nacks = 0; strobes = 0; prev_rd = 1'b0;
    for (int c = 0; c < 200 && nacks < 4; c++) begin
      @(negedge clk);
      if (rd && !prev_rd) strobes++;
      prev_rd = rd;
      if (ls_ack || if_ack) begin
        exp_if  = last_ls;
        exp_str = exp_if ? 2 : 1;
        checks++;
        if (if_ack !== exp_if || ls_ack !== !exp_if) begin
          failures++;
          $display("FAIL grant_order ack %0d: if_ack=%b ls_ack=%b required if_ack=%b", nacks, if_ack, ls_ack, exp_if);
        end
        checks++;
        if (strobes != exp_str) begin
          failures++;
          $display("FAIL strobes_per_txn ack %0d: got %0d required %0d", nacks, strobes, exp_str);
        end
        checks++;
        if (exp_if ? (if_instr !== {ref_mem[16'h0040], ref_mem[16'h0041]}) : (ls_rdata !== ref_mem[16'h0020])) begin
          failures++;
          $display("FAIL b2b_data ack %0d: instr=%h rdata=%h", nacks, if_instr, ls_rdata);
        end
        last_ls = !exp_if;
        strobes = 0;
        nacks++;
      end
    end
    checks++;
    if (nacks != 4) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d acks required 4", nacks);
    end
    ls_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_inta();
    run_txn(1'b1, 1'b0, 16'h0300, 16'h0000, 6, 1'b0);
    run_txn(1'b0, 1'b0, 16'h8300, 16'h0000, 3, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    bit f, w, mi;
    for (int i = 0; i < 24; i++) begin
      a  = 16'($urandom);
      d  = 16'($urandom);
      f  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      mi = 1'($urandom_range(0, 1));
      run_txn(f, w, a, d, 0, mi);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_addr = 16'h8100; if_req = 1'b1;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    checks++;
    if (rd !== 1'b1 || address_bus !== 16'h8101) begin
      failures++;
      $display("FAIL word1_strobe: rd=%b addr=%h required rd=1 addr=8101", rd, address_bus);
    end
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_fetch");
    reset = 1'b0; if_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (if_ack !== 1'b0 || rd !== 1'b0) begin
        failures++;
        $display("FAIL aborted_ack cycle %0d: if_ack=%b rd=%b required 0", k, if_ack, rd);
      end
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_wdata = '0; inta = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 16'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    test_reset();
    test_eprom_read();
    test_fetch();
    test_wrap();
    test_ram_write();
    test_eprom_write();
    test_back_to_back();
    test_inta();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
